// File: rtl/rc5_key_expand_if.sv
`timescale 1ns/1ps
// Control and table-read bundle for the RC5-16 key-schedule engine.
interface rc5_key_expand_if;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         ready;
  logic [5:0]   rd_idx;
  logic [15:0]  rd_data;

  modport master (
    output start, key, rd_idx,
    input  busy, ready, rd_data
  );

  modport slave (
    input  start, key, rd_idx,
    output busy, ready, rd_data
  );
endinterface

// File: rtl/rc5_key_expand.sv
`timescale 1ns/1ps
// RC5-16 key schedule: expands a 128-bit key into the 34-entry subkey table,
// one INIT entry or one MIX iteration per cycle, readable through a combinational port.
module rc5_key_expand #(
  parameter int unsigned       NUM_SUBKEYS = 34,
  parameter int unsigned       W           = 16,
  parameter logic [W-1:0]      P_W         = 16'hB7E1,
  parameter logic [W-1:0]      Q_W         = 16'h9E37
) (
  input  logic               clk,
  input  logic               rst,
  rc5_key_expand_if.slave    bus
);

  localparam int unsigned NUM_KEY_WORDS = 8;
  localparam int unsigned MIX_ITERS     = 3 * NUM_SUBKEYS;
  localparam logic [5:0]  LAST_I        = 6'(NUM_SUBKEYS - 1);
  localparam logic [6:0]  LAST_K        = 7'(MIX_ITERS - 1);

  typedef enum logic [1:0] {IDLE, INIT, MIX, READY} state_t;

  state_t         state, state_nxt;
  logic           accept;

  logic [W-1:0]   s_mem [NUM_SUBKEYS];
  logic [W-1:0]   l_mem [NUM_KEY_WORDS];
  logic [W-1:0]   a_reg, b_reg;
  logic [5:0]     i_idx;
  logic [2:0]     j_idx;
  logic [6:0]     k_cnt;

  logic [W-1:0]   init_val;
  logic [W-1:0]   a_sum, a_new, ab_sum, b_sum, b_new;
  logic [2*W-1:0] b_dbl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bus.busy  = 1'b0;
    bus.ready = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = INIT;
        end
      end
      INIT: begin
        bus.busy = 1'b1;
        if (i_idx == LAST_I) state_nxt = MIX;
      end
      MIX: begin
        bus.busy = 1'b1;
        if (k_cnt == LAST_K) state_nxt = READY;
      end
      READY: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = INIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    init_val = P_W;
    if (i_idx != '0) init_val = s_mem[i_idx - 6'd1] + Q_W;

    a_sum  = s_mem[i_idx] + a_reg + b_reg;
    a_new  = {a_sum[W-4:0], a_sum[W-1:W-3]};
    ab_sum = a_new + b_reg;
    b_sum  = l_mem[j_idx] + ab_sum;
    // Variable rotate: shift a doubled copy and keep the upper half.
    b_dbl  = {b_sum, b_sum} << ab_sum[3:0];
    b_new  = b_dbl[2*W-1:W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned n = 0; n < NUM_SUBKEYS; n++) s_mem[n] <= '0;
      for (int unsigned n = 0; n < NUM_KEY_WORDS; n++) l_mem[n] <= '0;
      a_reg <= '0;
      b_reg <= '0;
      i_idx <= '0;
      j_idx <= '0;
      k_cnt <= '0;
    end else if (accept) begin
      for (int unsigned n = 0; n < NUM_KEY_WORDS; n++) l_mem[n] <= bus.key[W*n +: W];
      a_reg <= '0;
      b_reg <= '0;
      i_idx <= '0;
      j_idx <= '0;
      k_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          s_mem[i_idx] <= init_val;
          i_idx        <= (i_idx == LAST_I) ? '0 : i_idx + 6'd1;
        end
        MIX: begin
          s_mem[i_idx] <= a_new;
          l_mem[j_idx] <= b_new;
          a_reg        <= a_new;
          b_reg        <= b_new;
          i_idx        <= (i_idx == LAST_I) ? '0 : i_idx + 6'd1;
          j_idx        <= j_idx + 3'd1;
          k_cnt        <= (k_cnt == LAST_K) ? '0 : k_cnt + 7'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rd_data = '0;
    if (bus.rd_idx < 6'(NUM_SUBKEYS)) bus.rd_data = s_mem[bus.rd_idx];
  end

endmodule

// File: tb/tb_rc5_key_expand.sv
`timescale 1ns/1ps
// Bench for rc5_key_expand: randomized keys against a reference key schedule, scoreboard-checked.
module tb_rc5_key_expand;

  typedef logic [33:0][15:0] table_t;
  typedef struct packed {
    table_t      s;
    logic [31:0] due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mon_owns;
  logic [5:0]  mon_idx;
  logic [5:0]  dir_idx;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [31:0] cyc        = '0;
  logic [31:0] busy_until = '0;
  exp_t        sb_q[$];

  rc5_key_expand_if bus();
  assign bus.rd_idx = mon_owns ? mon_idx : dir_idx;

  rc5_key_expand #(
    .NUM_SUBKEYS(34),
    .W(16),
    .P_W(16'hB7E1),
    .Q_W(16'h9E37)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] rotl(input logic [15:0] x, input logic [3:0] n);
    if (n == 4'd0) return x;
    return (x << n) | (x >> (5'd16 - {1'b0, n}));
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] x, input logic [3:0] n);
    if (n == 4'd0) return x;
    return (x >> n) | (x << (5'd16 - {1'b0, n}));
  endfunction

  // Textbook RC5 key expansion: S = P, P+Q, P+2Q, ...; then 3*max(t,c) mixing passes.
  function automatic table_t golden(input logic [127:0] key);
    logic [15:0] s [34];
    logic [15:0] l [8];
    logic [15:0] a, b, sum;
    table_t      t;
    for (int unsigned n = 0; n < 8; n++) l[n] = key[16*n +: 16];
    s[0] = 16'hB7E1;
    for (int unsigned n = 1; n < 34; n++) s[n] = s[n-1] + 16'h9E37;
    a = '0;
    b = '0;
    for (int unsigned it = 0; it < 102; it++) begin
      sum      = s[it % 34] + a + b;
      a        = rotl(sum, 4'd3);
      sum      = a + b;
      b        = rotl(l[it % 8] + sum, sum[3:0]);
      s[it % 34] = a;
      l[it % 8]  = b;
    end
    for (int unsigned n = 0; n < 34; n++) t[n] = s[n];
    return t;
  endfunction

  function automatic logic [31:0] rc5_enc(input logic [31:0] d, input table_t s);
    logic [15:0] a, b;
    a = d[15:0] + s[0];
    b = d[31:16] + s[1];
    for (int r = 1; r <= 12; r++) begin
      a = rotl(a ^ b, b[3:0]) + s[2*r];
      b = rotl(b ^ a, a[3:0]) + s[2*r+1];
    end
    return {b, a};
  endfunction

  function automatic logic [31:0] rc5_dec(input logic [31:0] d, input table_t s);
    logic [15:0] a, b;
    a = d[15:0];
    b = d[31:16];
    for (int r = 12; r >= 1; r--) begin
      b = rotr(b - s[2*r+1], a[3:0]) ^ a;
      a = rotr(a - s[2*r], b[3:0]) ^ b;
    end
    b = b - s[1];
    a = a - s[0];
    return {b, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic rd(input logic [5:0] idx, output logic [15:0] v);
    dir_idx = idx;
    #0.1;
    v = bus.rd_data;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic pulse_start(input logic [127:0] k);
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = k;
    @(negedge clk);
    bus.start = 1'b0;
    bus.key   = rand_key();
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  // Reference model: decides acceptance from the start level and the expansion window.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        sb_q.delete();
        busy_until = cyc;
      end else begin
        cyc++;
        if (bus.start && cyc > busy_until) begin
          exp_t e;
          e.s   = golden(bus.key);
          e.due = cyc + 32'd136;
          sb_q.push_back(e);
          busy_until = cyc + 32'd136;
        end
      end
    end
  end

  // Monitor: on each rising ready, pop the oldest expectation and sweep the read port.
  initial begin
    logic prev;
    prev     = 1'b0;
    mon_owns = 1'b0;
    mon_idx  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst && bus.ready && !prev) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ready: ready rose at cycle %0d with no schedule pending", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("ready_latency", cyc, e.due);
          mon_owns = 1'b1;
          for (int idx = 0; idx < 64; idx++) begin
            mon_idx = 6'(idx);
            #0.05;
            if (idx < 34) check($sformatf("S[%0d]", idx), {16'h0, bus.rd_data}, {16'h0, e.s[idx]});
            else          check($sformatf("rd_oob[%0d]", idx), {16'h0, bus.rd_data}, 32'h0);
          end
          mon_owns = 1'b0;
        end
      end
      prev = bus.ready;
    end
  end

  initial begin
    logic [15:0] v;
    table_t      tbl;
    logic [31:0] ct;

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.key   = '0;
    dir_idx   = '0;

    repeat (3) @(negedge clk);
    check("reset_busy",  32'(bus.busy),  32'd0);
    check("reset_ready", 32'(bus.ready), 32'd0);
    rd(6'd0, v);  check("reset_S0",  {16'h0, v}, 32'h0);
    rd(6'd33, v); check("reset_S33", {16'h0, v}, 32'h0);
    rst = 1'b1;

    // key = 0: table after INIT, then after the first MIX iteration
    pulse_start('0);
    repeat (34) @(posedge clk);
    #1;
    check("init_busy", 32'(bus.busy), 32'd1);
    rd(6'd0, v);  check("init_S0",  {16'h0, v}, 32'hB7E1);
    rd(6'd1, v);  check("init_S1",  {16'h0, v}, 32'h5618);
    rd(6'd2, v);  check("init_S2",  {16'h0, v}, 32'hF44F);
    rd(6'd33, v); check("init_S33", {16'h0, v}, 32'h1CF8);
    @(posedge clk);
    #1;
    rd(6'd0, v); check("mix1_S0", {16'h0, v}, 32'hBF0D);
    rd(6'd1, v); check("mix1_S1", {16'h0, v}, 32'h5618);
    wait_drain(200);

    // all-ones key with start pulses at E10 and E100 that must be ignored
    pulse_start('1);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.key   = rand_key();
    @(negedge clk);
    bus.start = 1'b0;
    repeat (89) @(negedge clk);
    bus.start = 1'b1;
    bus.key   = rand_key();
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain(200);

    pulse_start(128'h0F0E0D0C0B0A09080706050403020100);
    wait_drain(200);

    // round trip through a 12-round RC5 core using the table the block produced
    for (int n = 0; n < 34; n++) begin
      rd(6'(n), v);
      tbl[n] = v;
    end
    ct = rc5_enc(32'h12345678, tbl);
    check("roundtrip", rc5_dec(ct, tbl), 32'h12345678);

    // restart while READY
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = rand_key();
    @(posedge clk);
    #1;
    check("restart_ready", 32'(bus.ready), 32'd0);
    check("restart_busy",  32'(bus.busy),  32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain(200);

    for (int n = 0; n < 3; n++) begin
      pulse_start(rand_key());
      wait_drain(200);
    end

    // start held high: a new expansion begins each time READY is reached
    @(negedge clk);
    bus.start = 1'b1;
    for (int n = 0; n < 420; n++) begin
      bus.key = rand_key();
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_drain(200);

    // asynchronous reset in the middle of MIX
    pulse_start(rand_key());
    repeat (60) @(posedge clk);
    #2;
    rst = 1'b0;
    #0.5;
    check("abort_busy",  32'(bus.busy),  32'd0);
    check("abort_ready", 32'(bus.ready), 32'd0);
    rd(6'd0, v);  check("abort_S0",  {16'h0, v}, 32'h0);
    rd(6'd33, v); check("abort_S33", {16'h0, v}, 32'h0);
    rd(6'd40, v); check("abort_S40", {16'h0, v}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (150) @(negedge clk);
    check("idle_busy",  32'(bus.busy),  32'd0);
    check("idle_ready", 32'(bus.ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rc5_key_expand.md
# rc5_key_expand

RC5-16 key-schedule engine. It expands a 128-bit user key into the 34-entry, 16-bit subkey table S[0..33] that the RC5 round datapath consumes for up to 16 rounds. The table is held in an internal register file and read through a combinational read port. The block sits upstream of the encrypt/decrypt core and replaces a fixed subkey constant table with key-dependent subkeys.

## Interface

Parameters:
- NUM_SUBKEYS, 34, table depth t = 2*(16+1); fixed for RC5-16/16.
- W, 16, word width in bits; fixed.
- P_W, 16'hB7E1, RC5 magic constant P16.
- Q_W, 16'h9E37, RC5 magic constant Q16.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request expansion of key; level-sampled on posedge.
- key  input  128  user key, captured on accepted start; word L[i] = key[16i+15:16i], i=0..7.
- busy  output  1  high while INIT or MIX.
- ready  output  1  high while table holds a complete, valid schedule.
- rd_idx  input  6  subkey index to read.
- rd_data  output  16  S[rd_idx], combinational; 16'h0000 when rd_idx >= 34.

## Operation

- State registers: S[0..33], L[0..7], A, B, i (6b, 0..33), j (3b, 0..7), iteration counter k (7b, 0..101), FSM state.
- States are IDLE, INIT, MIX and READY.
- IDLE/READY + start=1: capture key into L[0..7], clear A, B, i, j and k, clear ready, go to INIT.
- INIT: one entry per cycle. S[i] <= (i==0) ? P_W : S[i-1] + Q_W, mod 2^16. i increments. After the write of S[33], clear i and go to MIX.
- MIX: one iteration per cycle, 102 iterations (3*max(34,8)).
  - A' = rotl(S[i] + A + B, 3); S[i] <= A'.
  - B' = rotl(L[j] + A' + B, (A' + B)[3:0]); L[j] <= B'.
  - A <= A', B <= B'.
  - i wraps 33->0; j wraps 7->0.
  - All sums are mod 2^16. The rotate amount is the low 4 bits of the 16-bit sum.
- After iteration k=101, go to READY.
- READY: ready=1. The table is stable until the next accepted start or reset.
- start while busy: ignored. The current expansion continues unaffected.
- start in READY: restart. ready drops on the accepting edge, and the old table is overwritten progressively.
- rd_data is valid only while ready=1. During busy it shows in-progress contents; consumers must not use them.
- The key input is don't-care except on the accepting edge.

## Timing

- Reset (async assert, any state): FSM=IDLE; S, L, A, B, i, j, k all 0. Outputs: busy=0, ready=0, rd_data=0 for every rd_idx.
- Reset deassertion is synchronized externally; the block leaves IDLE only on start.
- Let the accepting edge be E0. busy=1 from E0.
- INIT writes occur on edges E1..E34.
- MIX iterations occur on edges E35..E136.
- At E136, busy=0 and ready=1. Ready latency is 136 cycles from the accepting edge.
- Reset mid-INIT or mid-MIX: immediate abort to reset values. No partial table is retained.
- rd_data has zero-cycle latency from rd_idx and from table updates.

## Test plan

- Reset values: assert rst=0 mid-MIX -> busy=0, ready=0, and rd_data=0 for rd_idx=0, 33 and 40, asynchronously (before the next clk edge).
- INIT contents: start with key=0, then sample right after E34 -> S[0]=16'hB7E1, S[1]=16'h5618, S[2]=16'hF44F, S[33]=16'h1CF8.
- First MIX iteration: key=0, sample after E35 -> S[0]=16'hBF0D, while S[1] still equals 16'h5618.
- Full schedule and latency, for keys 0, all-ones and 128'h0F0E0D0C0B0A09080706050403020100:
  - ready rises exactly 136 cycles after start.
  - All 34 entries match the bench's golden RC5-16 key-schedule model.
  - rd_idx 34..63 returns 0.
- Handshake corners:
  - start pulsed at E10 and E100 during busy -> ignored; ready timing unchanged.
  - start in READY with a new key -> ready=0 on that edge, and the new table is correct 136 cycles later.
  - start held high continuously -> restarts each time READY is reached.
- Round trip: feed S[] into the RC5 round core for 12 rounds; encrypt then decrypt of d_in=32'h12345678 -> d_out=32'h12345678.
